// File: rtl/frog_pkg.sv
// Shared types and defaults for the frog jump controller.
// Optional arc feature is enabled with FROG_JUMP_ARC_EN.
package frog_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_WAIT   = 3'd2,
      S_LATCH  = 3'd3,
      S_FLY    = 3'd4,
      S_LAND   = 3'd5
   } jump_state_t;

   localparam logic GATE_A = 1'b0;
   localparam logic GATE_B = 1'b1;

   localparam int DEF_COORD_W = 11;
   localparam int DEF_MAX_X   = 639;
   localparam int DEF_MAX_Y   = 479;

   // Saturating 3-bit arc offset update: up while climbing, down while falling.
   function automatic logic [2:0] arc_next(input logic [2:0] off, input logic climbing);
      logic [2:0] res;
      if (climbing) begin
         if (off != 3'd7) res = off + 3'd1;
         else             res = off;
      end else begin
         if (off != 3'd0) res = off - 3'd1;
         else             res = off;
      end
      return res;
   endfunction

endpackage

// File: rtl/frog_jump_axis_stepper.sv
// One axis of frog motion: moves pos toward tgt by STEP, finishing with a
// partial step so the target is never overshot.
module axis_stepper
   import frog_pkg::*;
#(
   parameter int W    = DEF_COORD_W,
   parameter int STEP = 4
) (
   input  logic [W-1:0] pos,
   input  logic [W-1:0] tgt,
   input  logic         step_en,
   output logic [W-1:0] next_pos,
   output logic         at_tgt
);

   localparam logic [W-1:0] STEP_W = W'(STEP);

   logic [W-1:0] w_diff;

   // Compare before subtracting so the difference can never wrap.
   always_comb begin
      w_diff   = {W{1'b0}};
      next_pos = pos;
      if (step_en) begin
         if (tgt > pos) begin
            w_diff = tgt - pos;
            if (w_diff >= STEP_W) next_pos = pos + STEP_W;
            else                  next_pos = tgt;
         end else if (pos > tgt) begin
            w_diff = pos - tgt;
            if (w_diff >= STEP_W) next_pos = pos - STEP_W;
            else                  next_pos = tgt;
         end else begin
            next_pos = pos;
         end
      end else begin
         next_pos = pos;
      end
   end

   assign at_tgt = (next_pos == tgt);

endmodule

// File: rtl/frog_jump_ctrl.sv
// Jump initiator: drives the gate select, captures the selector's target and
// walks the frog there one STEP per frame. FROG_JUMP_ARC_EN adds a vertical arc.
module frog_jump_ctrl
   import frog_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int STEP    = 4,
   parameter int HOME_X  = 320,
   parameter int HOME_Y  = 440,
   parameter int MAX_X   = DEF_MAX_X,
   parameter int MAX_Y   = DEF_MAX_Y
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               startOfFrame,
   input  logic               jump_req,
   input  logic               gate_sel,
   output logic               control,
   input  logic [COORD_W-1:0] jumptoX,
   input  logic [COORD_W-1:0] jumptoY,
   output logic [COORD_W-1:0] frogX,
   output logic [COORD_W-1:0] frogY,
   output logic               busy,
   output logic               landed
);

   localparam logic [COORD_W-1:0] HOME_X_W = COORD_W'(HOME_X);
   localparam logic [COORD_W-1:0] HOME_Y_W = COORD_W'(HOME_Y);
   localparam logic [COORD_W-1:0] MAX_X_W  = COORD_W'(MAX_X);
   localparam logic [COORD_W-1:0] MAX_Y_W  = COORD_W'(MAX_Y);

   jump_state_t        r_state;
   logic               r_control;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [COORD_W-1:0] r_tgt_x;
   logic [COORD_W-1:0] r_tgt_y;
   logic               r_busy;
   logic               r_landed;

   logic [COORD_W-1:0] w_clamp_x;
   logic [COORD_W-1:0] w_clamp_y;
   logic [COORD_W-1:0] w_next_x;
   logic [COORD_W-1:0] w_next_y;
   logic               w_at_x;
   logic               w_at_y;
   logic               w_step_en;

   // Selector targets beyond the playfield are pulled back to its edge.
   always_comb begin
      if (jumptoX > MAX_X_W) w_clamp_x = MAX_X_W;
      else                   w_clamp_x = jumptoX;
      if (jumptoY > MAX_Y_W) w_clamp_y = MAX_Y_W;
      else                   w_clamp_y = jumptoY;
   end

   assign w_step_en = (r_state == S_FLY) && startOfFrame;

   axis_stepper #(.W(COORD_W), .STEP(STEP)) u_step_x (
      .pos      (r_x),
      .tgt      (r_tgt_x),
      .step_en  (w_step_en),
      .next_pos (w_next_x),
      .at_tgt   (w_at_x)
   );

   axis_stepper #(.W(COORD_W), .STEP(STEP)) u_step_y (
      .pos      (r_y),
      .tgt      (r_tgt_y),
      .step_en  (w_step_en),
      .next_pos (w_next_y),
      .at_tgt   (w_at_y)
   );

   // Jump sequencer with registered control, busy and landed.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_control <= GATE_A;
         r_x       <= HOME_X_W;
         r_y       <= HOME_Y_W;
         r_tgt_x   <= HOME_X_W;
         r_tgt_y   <= HOME_Y_W;
         r_busy    <= 1'b0;
         r_landed  <= 1'b0;
      end else begin
         r_landed <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (jump_req) begin
                  r_control <= gate_sel;
                  r_state   <= S_SELECT;
                  r_busy    <= 1'b1;
               end
            end
            S_SELECT: r_state <= S_WAIT;
            S_WAIT:   r_state <= S_LATCH;
            S_LATCH: begin
               r_tgt_x <= w_clamp_x;
               r_tgt_y <= w_clamp_y;
               if ((w_clamp_x == r_x) && (w_clamp_y == r_y)) begin
                  r_state  <= S_LAND;
                  r_landed <= 1'b1;
               end else begin
                  r_state <= S_FLY;
               end
            end
            S_FLY: begin
               if (w_step_en) begin
                  r_x <= w_next_x;
                  r_y <= w_next_y;
                  if (w_at_x && w_at_y) begin
                     r_state  <= S_LAND;
                     r_landed <= 1'b1;
                  end
               end
            end
            S_LAND: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign control = r_control;
   assign frogX   = r_x;
   assign busy    = r_busy;
   assign landed  = r_landed;

`ifdef FROG_JUMP_ARC_EN
   logic [2:0]         r_arc_off;
   logic [3:0]         r_arc_frames;
   logic [COORD_W-1:0] w_arc_ext;

   // Arc offset climbs for the first eight frames of flight, then falls.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_arc_off    <= 3'd0;
         r_arc_frames <= 4'd0;
      end else if (r_state != S_FLY) begin
         r_arc_off    <= 3'd0;
         r_arc_frames <= 4'd0;
      end else if (w_step_en && w_at_x && w_at_y) begin
         r_arc_off    <= 3'd0;
         r_arc_frames <= 4'd0;
      end else if (w_step_en) begin
         r_arc_off <= arc_next(r_arc_off, r_arc_frames < 4'd8);
         if (r_arc_frames < 4'd8) r_arc_frames <= r_arc_frames + 4'd1;
      end
   end

   assign w_arc_ext = COORD_W'(r_arc_off);
   assign frogY     = (r_y > w_arc_ext) ? (r_y - w_arc_ext) : {COORD_W{1'b0}};
`else
   assign frogY = r_y;
`endif

endmodule

// File: tb/tb_frog_jump_ctrl.sv
// Self-checking bench for frog_jump_ctrl: directed vector table, corner-case
// sequences and random jumps against a distance-based reference model.
module tb_frog_jump_ctrl;
   import frog_pkg::*;

   localparam int W      = 11;
   localparam int STEP   = 4;
   localparam int HOME_X = 320;
   localparam int HOME_Y = 440;
   localparam int MAX_X  = 639;
   localparam int MAX_Y  = 479;
`ifdef FROG_JUMP_ARC_EN
   localparam int ARC_ON = 1;
`else
   localparam int ARC_ON = 0;
`endif

   logic         CLK = 1'b0;
   logic         RESET;
   logic         startOfFrame;
   logic         jump_req;
   logic         gate_sel;
   logic         control;
   logic [W-1:0] jumptoX;
   logic [W-1:0] jumptoY;
   logic [W-1:0] frogX;
   logic [W-1:0] frogY;
   logic         busy;
   logic         landed;

   int   ga_x, ga_y, gb_x, gb_y;
   logic sel_r;
   int   checks = 0;
   int   failures = 0;
   int   cur_x, cur_y;

   typedef struct {
      bit g;
      int ax, ay, bx, by;
      bit poke;
      int ex, ey, ef;
   } vec_t;
   vec_t tbl[7];

   frog_jump_ctrl dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .startOfFrame (startOfFrame),
      .jump_req     (jump_req),
      .gate_sel     (gate_sel),
      .control      (control),
      .jumptoX      (jumptoX),
      .jumptoY      (jumptoY),
      .frogX        (frogX),
      .frogY        (frogY),
      .busy         (busy),
      .landed       (landed)
   );

   always #5 CLK = ~CLK;

   // Selector stand-in: registers the gate select, answers one cycle later.
   always @(posedge CLK) sel_r <= control;
   assign jumptoX = sel_r ? W'(gb_x) : W'(ga_x);
   assign jumptoY = sel_r ? W'(gb_y) : W'(ga_y);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Position after k frames: distance covered is k*STEP, capped at the gap.
   function automatic int model_axis(input int s, input int t, input int k);
      int mv;
      mv = k * STEP;
      if (mv > absd(s, t)) mv = absd(s, t);
      return (t >= s) ? s + mv : s - mv;
   endfunction

   function automatic int frames_needed(input int sx, input int sy, input int tx, input int ty);
      int d;
      d = (absd(sx, tx) > absd(sy, ty)) ? absd(sx, tx) : absd(sy, ty);
      return (d + STEP - 1) / STEP;
   endfunction

   // Displayed Y: rises 1..7 over the first 8 frames, then sinks, 0 on landing.
   function automatic int disp_y(input int y, input int k, input bit fin);
      int off;
      if (fin || k == 0)  off = 0;
      else if (k <= 8)    off = (k < 7) ? k : 7;
      else                off = (15 - k > 0) ? 15 - k : 0;
      off = off * ARC_ON;
      return (y > off) ? y - off : 0;
   endfunction

   task automatic do_jump(input bit g, input int ax, input int ay, input int bx, input int by,
                          input bit poke, output int frames);
      int tx, ty, nf, gap;
      ga_x = ax; ga_y = ay; gb_x = bx; gb_y = by;
      tx = g ? bx : ax;
      ty = g ? by : ay;
      if (tx > MAX_X) tx = MAX_X;
      if (ty > MAX_Y) ty = MAX_Y;
      nf = frames_needed(cur_x, cur_y, tx, ty);

      gate_sel = g;
      jump_req = 1'b1;
      tick();
      jump_req = 1'b0;
      gate_sel = ~g;
      chk("control_after_req", int'(control), int'(g));
      chk("busy_after_req", int'(busy), 1);
      tick();
      tick();
      chk("busy_wait", int'(busy), 1);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      chk("latch_x_still", int'(frogX), cur_x);

      frames = 0;
      while (!landed && frames < 300) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            tick();
            chk("gap_x", int'(frogX), model_axis(cur_x, tx, frames));
         end
         if (poke && frames == 1) begin
            jump_req = 1'b1;
            gate_sel = ~g;
         end
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         jump_req = 1'b0;
         frames++;
         chk("frame_x", int'(frogX), model_axis(cur_x, tx, frames));
         chk("frame_y", int'(frogY), disp_y(model_axis(cur_y, ty, frames), frames, frames == nf));
         chk("landed_at_frame", int'(landed), int'(frames == nf));
      end
      chk("frame_count", frames, nf);
      chk("control_hold", int'(control), int'(g));
      chk("busy_landing", int'(busy), 1);
      if (poke) jump_req = 1'b1;
      tick();
      jump_req = 1'b0;
      chk("landed_pulse_end", int'(landed), 0);
      chk("busy_idle", int'(busy), 0);
      tick();
      chk("land_req_ignored", int'(busy), 0);
      cur_x = tx;
      cur_y = ty;
   endtask

   initial begin
      int fr;
      tbl[0] = '{1'b1,   0,   0, 100, 200, 1'b0, 100, 200,  60};
      tbl[1] = '{1'b0, 103, 190, 600,  10, 1'b1, 103, 190,   3};
      tbl[2] = '{1'b1,   5,   5, 700, 500, 1'b0, 639, 479, 134};
      tbl[3] = '{1'b0, 639, 479,   0,   0, 1'b1, 639, 479,   0};
      tbl[4] = '{1'b1,   0,   0, 320, 440, 1'b0, 320, 440,  80};
      tbl[5] = '{1'b0, 323, 430,   9,   9, 1'b0, 323, 430,   3};
      tbl[6] = '{1'b1,   1,   1, 323, 366, 1'b1, 323, 366,  16};

      RESET = 1'b1;
      startOfFrame = 1'b0;
      jump_req = 1'b0;
      gate_sel = 1'b1;
      ga_x = 0; ga_y = 0; gb_x = 0; gb_y = 0;
      tick();
      tick();
      chk("rst_x", int'(frogX), HOME_X);
      chk("rst_y", int'(frogY), HOME_Y);
      chk("rst_control", int'(control), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_landed", int'(landed), 0);
      RESET = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);
      cur_x = HOME_X;
      cur_y = HOME_Y;

      for (int i = 0; i < 7; i++) begin
         do_jump(tbl[i].g, tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].poke, fr);
         chk("vec_frames", fr, tbl[i].ef);
         chk("vec_final_x", int'(frogX), tbl[i].ex);
         chk("vec_final_y", int'(frogY), tbl[i].ey);
      end

      // Abort a jump with reset partway through its fifth frame.
      gb_x = 100; gb_y = 200;
      gate_sel = 1'b1;
      jump_req = 1'b1;
      tick();
      jump_req = 1'b0;
      repeat (3) tick();
      repeat (4) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         tick();
      end
      chk("pre_reset_busy", int'(busy), 1);
      startOfFrame = 1'b1;
      RESET = 1'b1;
      tick();
      startOfFrame = 1'b0;
      RESET = 1'b0;
      chk("midrst_x", int'(frogX), HOME_X);
      chk("midrst_y", int'(frogY), HOME_Y);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_landed", int'(landed), 0);
      chk("midrst_control", int'(control), 0);
      tick();
      chk("midrst_no_land", int'(landed), 0);
      chk("midrst_idle", int'(busy), 0);
      cur_x = HOME_X;
      cur_y = HOME_Y;

      for (int r = 0; r < 10; r++) begin
         do_jump(bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 767)), int'($urandom_range(0, 600)),
                 int'($urandom_range(0, 767)), int'($urandom_range(0, 600)),
                 bit'($urandom_range(0, 1)), fr);
         chk("rand_final_x", int'(frogX), cur_x);
         chk("rand_final_y", int'(frogY), cur_y);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frog_jump_ctrl.md
Name: frog_jump_ctrl

Overview:
- Initiator side of the gate-select/jump-target interface.
- On a player jump request, drives the gate-select `control` line and waits out the selector's one-cycle registered latency. It then captures the returned jump target and moves the frog there in fixed pixel steps, one step per video frame.
- Sits between the keyboard/game-logic layer and the frog drawing object; `frogX`/`frogY` feed the frog's top-left drawing coordinates.

Parameters:
- COORD_W, 11, coordinate width in bits for all X/Y ports.
- STEP, 4, pixels moved per axis per frame; must be ≥1.
- HOME_X, 320, frog X after reset.
- HOME_Y, 440, frog Y after reset.
- MAX_X, 639, target X is clamped to this.
- MAX_Y, 479, target Y is clamped to this.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- jump_req  in  1  one-cycle jump request from game logic.
- gate_sel  in  1  requested gate: 0 = gate A, 1 = gate B.
- control  out  1  gate select driven to the selector.
- jumptoX  in  COORD_W  target X returned by the selector, registered there with 1-cycle latency.
- jumptoY  in  COORD_W  target Y returned by the selector.
- frogX  out  COORD_W  current frog X.
- frogY  out  COORD_W  current frog Y, including arc offset when the optional feature is enabled.
- busy  out  1  high in every state except IDLE.
- landed  out  1  one-cycle pulse when the frog reaches its target.

Behaviour:
- Reset values (RESET high at a CLK edge):
  - state = IDLE, control = 0, frogX = HOME_X, frogY = HOME_Y, busy = 0, landed = 0.
  - Internal target registers = HOME.
  - Reset mid-jump aborts immediately: no landed pulse, frog snaps to HOME.
- States: IDLE, SELECT, WAIT, LATCH, FLY, LAND.
- IDLE:
  - On jump_req = 1: register control <= gate_sel and go to SELECT.
  - control holds its last value in IDLE.
- SELECT: one cycle, gives the selector an edge to register the new select. Go to WAIT.
- WAIT: one cycle; selector outputs are now valid. Go to LATCH.
- LATCH:
  - tgtX <= min(jumptoX, MAX_X); tgtY <= min(jumptoY, MAX_Y).
  - If the target equals the current position, go to LAND; otherwise go to FLY.
- FLY: on each startOfFrame pulse, each axis independently moves toward its target.
  - If |tgt − pos| ≥ STEP: pos ± STEP; otherwise pos = tgt.
  - Differences are computed unsigned via compare-then-subtract, so no wrap is possible.
  - When both axes equal their targets after an update, go to LAND on the next cycle.
  - Cycles without startOfFrame leave the position unchanged.
- LAND: landed = 1 for exactly one cycle, then return to IDLE.
- jump_req outside IDLE is ignored, not queued. A jump_req on the same cycle as LAND→IDLE is also ignored.
- startOfFrame in SELECT, WAIT, LATCH or LAND has no effect.
- gate_sel is sampled only on the accepted jump_req; later changes do nothing until the next jump.
- Latency: jump_req → target captured = 3 cycles. Jump duration = ceil(max(|dx|, |dy|) / STEP) frames.

Optional Feature:
- Macro: FROG_JUMP_ARC_EN.
- When defined:
  - A 3-bit arc offset counter runs during FLY.
  - For the first 8 frames of a jump it increments on each startOfFrame, saturating at 7.
  - After that it decrements on each startOfFrame, saturating at 0.
  - frogY output = internal Y − offset, floored at 0.
  - The offset is forced to 0 in LAND, IDLE and on reset.
  - Arrival is judged on internal Y only.
- When undefined: no counter is built and frogY = internal Y.

Decomposition:
- Package frog_pkg holds:
  - the state enum jump_state_t;
  - constants GATE_A = 0 and GATE_B = 1;
  - default COORD_W and the screen limits MAX_X/MAX_Y.
- Sub-module axis_stepper, instantiated twice (X and Y):
  - inputs: pos, tgt, step_en;
  - outputs: next_pos, at_tgt;
  - implements the STEP/clamp rule.

Test Plan:
- Reset: RESET high 2 cycles → frogX = 320, frogY = 440, control = 0, busy = 0, landed = 0.
- Gate B jump:
  - Stimulus: gate_sel = 1 with jump_req; selector returns (100, 200) from (320, 440); STEP = 4.
  - Response: control = 1 after 1 cycle; target latched at cycle 3; landed after 60 frames; final (100, 200).
- Non-multiple distance:
  - Stimulus: target (323, 430).
  - Response: X reaches 323 on frame 1 (partial step of 3); landed after 3 frames at Y = 430.
- Ignored request and clamp:
  - Stimulus: jump_req during FLY; later a target of (700, 500).
  - Response: the mid-flight request has no effect; the new target clamps to (639, 479).
- Reset mid-flight: RESET asserted during frame 5 of a jump → next cycle frog at (320, 440), IDLE, no landed pulse.
- FROG_JUMP_ARC_EN:
  - Stimulus: 16-frame vertical jump.
  - Response: frogY output is offset by 1..7 during flight, and the offset is 0 on the landed cycle.
